keyin_debounce_enc: RTL



---
 rtl/keyin_debounce_enc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/keyin_debounce_enc.sv
// Key input block: 2-flop synchronisers on NUM_KEYS raw buttons, a priority encoder
// and one shared debounce FSM producing a stable code plus press/release/repeat strobes.
module keyin_debounce_enc #(
   parameter int unsigned  NUM_KEYS        = 5,
   parameter int unsigned  DEBOUNCE_CYCLES = 200000,
   parameter int unsigned  REPEAT_EN       = 1,
   parameter int unsigned  REPEAT_DELAY    = 25000000,
   parameter int unsigned  REPEAT_PERIOD   = 5000000,
   localparam int unsigned CODE_W          = $clog2(NUM_KEYS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_KEYS-1:0] key,
   output logic [CODE_W-1:0] key_out,
   output logic              key_valid,
   output logic              key_press,
   output logic              key_release,
   output logic              key_repeat
);

   localparam int unsigned CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RCNT_W     = $clog2(REPEAT_MAX + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] RPT_DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RPT_PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } state_t;

   logic [NUM_KEYS-1:0] sync1_q, sync1_d;
   logic [NUM_KEYS-1:0] sync2_q, sync2_d;
   logic [CODE_W-1:0]   cand;

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   lat_q, lat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
   logic                rep_phase_q, rep_phase_d;
   logic [CODE_W-1:0]   key_out_q, key_out_d;
   logic                key_valid_q, key_valid_d;
   logic                key_press_q, key_press_d;
   logic                key_release_q, key_release_d;
   logic                key_repeat_q, key_repeat_d;

   always_comb begin
      sync1_d = key;
      sync2_d = sync1_q;
   end

   // Scan from the top so the lowest-index pressed key is the last assignment and wins.
   always_comb begin
      cand = '0;
      for (int unsigned i = NUM_KEYS; i > 0; i--) begin
         if (sync2_q[i-1]) cand = CODE_W'(i);
      end
   end

   always_comb begin
      state_d       = state_q;
      lat_d         = lat_q;
      cnt_d         = cnt_q;
      rcnt_d        = rcnt_q;
      rep_phase_d   = rep_phase_q;
      key_out_d     = key_out_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      key_repeat_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (cand != '0) begin
               lat_d   = cand;
               cnt_d   = '0;
               state_d = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (cand != lat_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = HELD;
               key_out_d   = lat_q;
               key_press_d = 1'b1;
               rcnt_d      = '0;
               rep_phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (cand != lat_q) begin
               state_d = REL_WAIT;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               // rep_phase selects the initial delay or the steady repeat period.
               if (rcnt_q == (rep_phase_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                  key_repeat_d = 1'b1;
                  rcnt_d       = '0;
                  rep_phase_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
         REL_WAIT: begin
            if (cand == lat_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = IDLE;
               key_out_d     = '0;
               key_release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      key_valid_d = (key_out_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         state_q       <= IDLE;
         lat_q         <= '0;
         cnt_q         <= '0;
         rcnt_q        <= '0;
         rep_phase_q   <= 1'b0;
         key_out_q     <= '0;
         key_valid_q   <= 1'b0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
         key_repeat_q  <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         state_q       <= state_d;
         lat_q         <= lat_d;
         cnt_q         <= cnt_d;
         rcnt_q        <= rcnt_d;
         rep_phase_q   <= rep_phase_d;
         key_out_q     <= key_out_d;
         key_valid_q   <= key_valid_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         key_repeat_q  <= key_repeat_d;
      end
   end

   assign key_out     = key_out_q;
   assign key_valid   = key_valid_q;
   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign key_repeat  = key_repeat_q;

endmodule
